// File: rtl/gpio_axi_lite_core.sv
// GPIO register/pin stage behind an AXI-Lite BRAM-style port: out/dir/in-sync/edge-irq registers.
// Reads return one cycle after the strobe and hold; writes land on the strobe edge; no backpressure.
module gpio_axi_lite_core #(
  parameter int          GPIO_W   = 32,
  parameter int          OFFSET_W = 5,
  parameter logic [31:0] DOUT_RST = 32'h0
) (
  input  logic              s_axi_aclk,
  input  logic              s_axi_areset,
  input  logic [31:0]       bram_addr,
  input  logic [31:0]       bram_wr_data,
  output logic [31:0]       bram_rd_data,
  input  logic              bram_en,
  input  logic              bram_we,
  input  logic              bram_re,
  input  logic [GPIO_W-1:0] gpio_in,
  output logic [GPIO_W-1:0] gpio_out,
  output logic [GPIO_W-1:0] gpio_oe,
  output logic              irq
);

  localparam int WA = OFFSET_W - 2;
  localparam logic [WA-1:0] OFF_DOUT = WA'(0);
  localparam logic [WA-1:0] OFF_DIR  = WA'(1);
  localparam logic [WA-1:0] OFF_DIN  = WA'(2);
  localparam logic [WA-1:0] OFF_MASK = WA'(3);
  localparam logic [WA-1:0] OFF_POL  = WA'(4);
  localparam logic [WA-1:0] OFF_STAT = WA'(5);
  localparam logic [WA-1:0] OFF_SET  = WA'(6);
  localparam logic [WA-1:0] OFF_CLR  = WA'(7);

  logic [WA-1:0]     woff;
  logic [GPIO_W-1:0] wdat;
  logic [GPIO_W-1:0] dout, dir, imask, ipol, istat;
  logic [GPIO_W-1:0] sync1, sync2, prev;
  logic [GPIO_W-1:0] rise, fall, edge_hit, w1c;
  logic [31:0]       rd_mux;
  logic              unused_addr;

  assign woff        = bram_addr[OFFSET_W-1:2];
  assign wdat        = bram_wr_data[GPIO_W-1:0];
  assign unused_addr = ^{bram_addr[31:OFFSET_W], bram_addr[1:0]};

  assign rise     = sync2 & ~prev;
  assign fall     = ~sync2 & prev;
  assign edge_hit = (ipol & fall) | (~ipol & rise);
  assign w1c      = (bram_we && woff == OFF_STAT) ? wdat : '0;

  always_comb begin
    rd_mux = '0;
    case (woff)
      OFF_DOUT: rd_mux = 32'(dout);
      OFF_DIR:  rd_mux = 32'(dir);
      OFF_DIN:  rd_mux = 32'(sync2);
      OFF_MASK: rd_mux = 32'(imask);
      OFF_POL:  rd_mux = 32'(ipol);
      OFF_STAT: rd_mux = 32'(istat);
      default:  rd_mux = '0;
    endcase
  end

  always_ff @(posedge s_axi_aclk) begin
    if (s_axi_areset) begin
      dout         <= DOUT_RST[GPIO_W-1:0];
      dir          <= '0;
      imask        <= '0;
      ipol         <= '0;
      istat        <= '0;
      sync1        <= '0;
      sync2        <= '0;
      prev         <= '0;
      irq          <= 1'b0;
      bram_rd_data <= '0;
    end else begin
      sync1 <= gpio_in;
      sync2 <= sync1;
      prev  <= sync2;
      if (bram_we) begin
        case (woff)
          OFF_DOUT: dout  <= wdat;
          OFF_DIR:  dir   <= wdat;
          OFF_MASK: imask <= wdat;
          OFF_POL:  ipol  <= wdat;
          OFF_SET:  dout  <= dout | wdat;
          OFF_CLR:  dout  <= dout & ~wdat;
          default:  ;
        endcase
      end
      // A fresh edge outranks a same-cycle W1C so no event is lost.
      istat <= (istat & ~w1c) | edge_hit;
      irq   <= |(istat & imask);
      if (bram_en && bram_re)
        bram_rd_data <= rd_mux;
    end
  end

  assign gpio_out = dout;
  assign gpio_oe  = dir;

endmodule

// File: tb/tb_gpio_axi_lite_core.sv
// Scoreboard bench for gpio_axi_lite_core: read expectations are queued at the strobe and checked at return.
module tb_gpio_axi_lite_core;

  localparam logic [31:0] DRST = 32'h1234_0000;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] addr = '0, wr_data = '0, rd_data;
  logic        en = 1'b0, we = 1'b0, re = 1'b0;
  logic [31:0] gpio_in = '0, gpio_out, gpio_oe;
  logic        irq;

  int          n_vec = 0;
  int          n_err = 0;
  logic [31:0] exp_q[$];

  gpio_axi_lite_core #(.GPIO_W(32), .OFFSET_W(5), .DOUT_RST(DRST)) dut (
    .s_axi_aclk   (clk),
    .s_axi_areset (rst),
    .bram_addr    (addr),
    .bram_wr_data (wr_data),
    .bram_rd_data (rd_data),
    .bram_en      (en),
    .bram_we      (we),
    .bram_re      (re),
    .gpio_in      (gpio_in),
    .gpio_out     (gpio_out),
    .gpio_oe      (gpio_oe),
    .irq          (irq)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %08h expected %08h", tag, obs, exp);
    end
  endtask

  // All tasks start and end on a falling edge.
  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    addr = a; wr_data = d; we = 1'b1;
    @(negedge clk);
    we = 1'b0;
  endtask

  task automatic rd(input string tag, input logic [31:0] a, input logic [31:0] e);
    addr = a; en = 1'b1; re = 1'b1;
    exp_q.push_back(e);
    @(negedge clk);
    en = 1'b0; re = 1'b0;
    chk(tag, rd_data, exp_q.pop_front());
  endtask

  task automatic rdwr(input string tag, input logic [31:0] a, input logic [31:0] d, input logic [31:0] e);
    addr = a; wr_data = d; en = 1'b1; re = 1'b1; we = 1'b1;
    exp_q.push_back(e);
    @(negedge clk);
    en = 1'b0; re = 1'b0; we = 1'b0;
    chk(tag, rd_data, exp_q.pop_front());
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    idle(3);
    rst = 1'b0;
    chk("rst_rd_data", rd_data, 32'h0);
    chk("rst_oe", gpio_oe, 32'h0);
    chk("rst_out", gpio_out, DRST);
    chk("rst_irq", {31'h0, irq}, 32'h0);
    for (int i = 0; i < 8; i++)
      rd($sformatf("rst_off%02h", i * 4), 32'(i * 4), (i == 0) ? DRST : 32'h0);

    // Output path: DIR, DATA_OUT, SET, CLR
    wr(32'h04, 32'h0000_00FF);
    wr(32'h00, 32'hA5A5_A5A5);
    wr(32'h18, 32'h0F00_0000);
    wr(32'h1C, 32'h0000_0005);
    chk("oe", gpio_oe, 32'h0000_00FF);
    chk("out", gpio_out, 32'hAFA5_A5A0);
    rd("rd_dout", 32'h00, 32'hAFA5_A5A0);
    idle(2);
    chk("rd_hold", rd_data, 32'hAFA5_A5A0);
    rd("rd_set_zero", 32'h18, 32'h0);
    rd("rd_clr_zero", 32'h1C, 32'h0);
    rd("rd_alias_hi", 32'h124, 32'h0000_00FF);

    // Input sync latency and read-during-write
    gpio_in = 32'h3;
    rd("din_p1", 32'h08, 32'h0);
    rd("din_p2", 32'h08, 32'h0);
    rd("din_p3", 32'h08, 32'h3);
    rdwr("rdwr_old", 32'h00, 32'h1111_2222, 32'hAFA5_A5A0);
    rd("rd_new", 32'h00, 32'h1111_2222);
    chk("out_new", gpio_out, 32'h1111_2222);
    rd("stat_rise", 32'h14, 32'h3);
    chk("irq_masked", {31'h0, irq}, 32'h0);
    wr(32'h14, 32'hFFFF_FFFF);
    rd("stat_clr", 32'h14, 32'h0);

    // Rising on bit 0, falling on bit 1
    wr(32'h10, 32'h2);
    gpio_in = 32'h2;
    idle(4);
    wr(32'h14, 32'hFFFF_FFFF);
    rd("stat_pre", 32'h14, 32'h0);
    wr(32'h0C, 32'h1);
    gpio_in = 32'h1;
    idle(3);
    chk("irq_pad3", {31'h0, irq}, 32'h0);
    idle(1);
    chk("irq_pad4", {31'h0, irq}, 32'h1);
    rd("stat_edges", 32'h14, 32'h3);
    wr(32'h14, 32'h1);
    idle(1);
    chk("irq_w1c", {31'h0, irq}, 32'h0);
    rd("stat_w1c", 32'h14, 32'h2);
    wr(32'h0C, 32'h2);
    idle(1);
    chk("irq_mask2", {31'h0, irq}, 32'h1);
    wr(32'h0C, 32'h0);
    idle(1);
    chk("irq_mask0", {31'h0, irq}, 32'h0);
    rd("stat_kept", 32'h14, 32'h2);
    wr(32'h0C, 32'h1);

    // W1C colliding with a new rising edge on bit 0
    gpio_in = 32'h0;
    idle(4);
    wr(32'h14, 32'hFFFF_FFFF);
    idle(1);
    chk("irq_idle", {31'h0, irq}, 32'h0);
    rd("stat_idle", 32'h14, 32'h0);
    gpio_in = 32'h1;
    idle(2);
    wr(32'h14, 32'h1);
    idle(1);
    chk("irq_collide", {31'h0, irq}, 32'h1);
    rd("stat_collide", 32'h14, 32'h1);
    wr(32'h14, 32'h1);
    idle(1);
    chk("irq_clr2", {31'h0, irq}, 32'h0);
    rd("stat_clr2", 32'h14, 32'h0);

    // Mid-operation reset
    wr(32'h10, 32'h0);
    gpio_in = 32'h0;
    idle(4);
    wr(32'h14, 32'hFFFF_FFFF);
    gpio_in = 32'hFF;
    idle(4);
    rd("stat_ff", 32'h14, 32'hFF);
    wr(32'h0C, 32'hFF);
    idle(1);
    chk("irq_ff", {31'h0, irq}, 32'h1);
    gpio_in = 32'h0;
    idle(4);
    rd("stat_ff_keep", 32'h14, 32'hFF);
    rst = 1'b1;
    idle(1);
    rst = 1'b0;
    chk("mrst_oe", gpio_oe, 32'h0);
    chk("mrst_out", gpio_out, DRST);
    chk("mrst_irq", {31'h0, irq}, 32'h0);
    chk("mrst_rd_data", rd_data, 32'h0);
    idle(5);
    chk("mrst_irq_late", {31'h0, irq}, 32'h0);
    rd("mrst_dout", 32'h00, DRST);
    rd("mrst_dir", 32'h04, 32'h0);
    rd("mrst_mask", 32'h0C, 32'h0);
    rd("mrst_pol", 32'h10, 32'h0);
    rd("mrst_stat", 32'h14, 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/gpio_axi_lite_core.md
Name: gpio_axi_lite_core

Overview:
- Register/pin stage directly downstream of the AXI-Lite slave interface.
- Consumes its BRAM-style register port (bram_addr/wr_data/en/we/re) and returns bram_rd_data.
- Holds GPIO output, direction, input-sync, and edge-interrupt registers, and drives the pads.
- Produces one level interrupt for the SoC interrupt controller.

Parameters:
- GPIO_W, 32, number of GPIO pins (1..32); register bits above GPIO_W read 0 and ignore writes.
- OFFSET_W, 5, low bram_addr bits decoded; higher bits ignored.
- DOUT_RST, 32'h0, reset value of DATA_OUT.

Ports:
- s_axi_aclk  in  1  clock, rising edge.
- s_axi_areset  in  1  reset; synchronous, active-high.
- bram_addr  in  32  byte address; word offset = bram_addr[OFFSET_W-1:2].
- bram_wr_data  in  32  write data.
- bram_rd_data  out  32  registered read data.
- bram_en  in  1  access strobe; qualifies bram_re.
- bram_we  in  1  write strobe, one-cycle pulse.
- bram_re  in  1  read strobe.
- gpio_in  in  GPIO_W  asynchronous pad inputs.
- gpio_out  out  GPIO_W  pad output values.
- gpio_oe  out  GPIO_W  pad output enables, 1 = drive.
- irq  out  1  level interrupt, registered.

Behaviour:
- Clock and reset: single clock s_axi_aclk; reset s_axi_areset is synchronous, active-high.
- Reset values:
  - DATA_OUT = DOUT_RST; DIR = 0; IRQ_MASK = 0; IRQ_POL = 0; IRQ_STATUS = 0.
  - Sync flops = 0; bram_rd_data = 0; irq = 0.
  - gpio_out = DOUT_RST; gpio_oe = 0.
- Register map (word offset):
  - 0x00 DATA_OUT RW.
  - 0x04 DIR RW, drives gpio_oe.
  - 0x08 DATA_IN RO.
  - 0x0C IRQ_MASK RW.
  - 0x10 IRQ_POL RW: 0 = rising, 1 = falling.
  - 0x14 IRQ_STATUS R/W1C.
  - 0x18 SET WO: DATA_OUT |= wdata.
  - 0x1C CLR WO: DATA_OUT &= ~wdata.
  - SET/CLR read 0. Unmapped offsets read 0; writes to them are ignored. No error response.
- Write path:
  - Register updates on the clock edge where bram_we=1.
  - gpio_out/gpio_oe reflect the new value one cycle after the bram_we edge.
- Read path:
  - bram_rd_data updates on the edge where bram_en=1 and bram_re=1. One-cycle latency.
  - bram_rd_data holds its value until the next read; it is not cleared.
  - Upstream samples it two cycles after the strobe, so holding is mandatory.
- Write and read in the same cycle: write takes effect; read returns the pre-write value.
- Input sync and edge detect:
  - gpio_in passes through 2 flops, sync1 then sync2. DATA_IN = sync2.
  - A third flop, prev, holds the previous sync2.
  - Rising edge = sync2 & ~prev. Falling edge = ~sync2 & prev.
  - edge_hit[i] = IRQ_POL[i] ? fall[i] : rise[i].
  - Pad-to-DATA_IN latency is 2 cycles; pad-to-STATUS set is 3 cycles.
- IRQ_STATUS:
  - Each bit is sticky: set on edge_hit regardless of mask.
  - Cleared by writing 1 to offset 0x14.
  - Edge set and W1C clear on the same bit in the same cycle: set wins.
  - Bits outside GPIO_W stay 0.
- irq = registered |(IRQ_STATUS & IRQ_MASK). It asserts one cycle after the status bit sets.
  - Masking an already-set bit drops irq the next cycle; the status bit is kept.
- Output readback: gpio_out always equals DATA_OUT, independent of DIR.
  - Pads with DIR=0 still update DATA_OUT.
- Reset mid-operation: all registers return to reset values on the next edge.
  - Edges occurring during reset are not recorded.
  - After release, the first 3 cycles compare against reset-zero sync history. Pads held high through reset therefore set a rising-edge STATUS bit after release; this is intended.

Test Plan:
- Reset, then read each offset 0x00–0x1C -> 0x0, except 0x00 = DOUT_RST. gpio_oe=0, irq=0.
- Write 0x04=0x0000_00FF, then 0x00=0xA5A5_A5A5, then 0x18=0x0F00_0000, then 0x1C=0x0000_0005:
  - gpio_oe=0xFF; gpio_out=0xAFA5_A5A0.
  - Read 0x00 returns 0xAFA5_A5A0.
- Drive gpio_in=0x0000_0003 at cycle t -> DATA_IN reads 0x3 from t+2. Read issued with simultaneous write to 0x00 returns the old DATA_OUT.
- Set IRQ_MASK=0x1 and IRQ_POL=0x2, then pulse gpio_in[0] 0→1 and gpio_in[1] 1→0:
  - IRQ_STATUS=0x3; irq=1 at pad+4.
  - Write 0x14=0x1 -> STATUS=0x2, irq=0 next cycle.
- W1C of bit 0 in the exact cycle a new rising edge on bit 0 is detected -> STATUS[0] stays 1, irq stays 1.
- Assert s_axi_areset for 1 cycle with STATUS=0xFF, DIR=0xFF -> all registers and outputs back to reset values on the following edge. No spurious irq while gpio_in is held 0.
